pipeline_hazard_controller: RTL and testbench

- Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) and decides each cycle whether it advances, stalls or flushes.
- Load-use hazards: inserts a single bubble by holding PC and IF/ID and flushing ID/EX.
- Redirects: a taken branch resolved in EX/MEM flushes IF/ID, ID/EX and EX/MEM; a jump in ID/EX flushes IF/ID and ID/EX.
- Keeps saturating stall and flush event counters for program-level performance checks.

---
 rtl/pipeline_hazard_controller_if.sv | 37 +++
 rtl/pipeline_hazard_controller.sv | 97 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave); signal suffixes are from the controller's view.
interface pipeline_hazard_controller_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned COUNT_WIDTH    = 16
);
    logic [REG_ADDR_WIDTH-1:0] id_rs_i;
    logic [REG_ADDR_WIDTH-1:0] id_rt_i;
    logic                      id_uses_rt_i;
    logic                      ex_mem_read_i;
    logic [REG_ADDR_WIDTH-1:0] ex_rt_i;
    logic                      ex_jump_i;
    logic                      mem_branch_taken_i;
    logic                      count_clear_i;
    logic                      pc_enable_o;
    logic                      ifid_enable_o;
    logic                      ifid_flush_o;
    logic                      idex_flush_o;
    logic                      exmem_flush_o;
    logic [1:0]                state_o;
    logic [COUNT_WIDTH-1:0]    stall_count_o;
    logic [COUNT_WIDTH-1:0]    flush_count_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
               ex_jump_i, mem_branch_taken_i, count_clear_i,
        input  pc_enable_o, ifid_enable_o, ifid_flush_o, idex_flush_o,
               exmem_flush_o, state_o, stall_count_o, flush_count_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
               ex_jump_i, mem_branch_taken_i, count_clear_i,
        output pc_enable_o, ifid_enable_o, ifid_flush_o, idex_flush_o,
               exmem_flush_o, state_o, stall_count_o, flush_count_o
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage MIPS hazard controller: single-bubble load-use stalls, branch/jump
// flushes, and saturating stall/flush event counters.
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [COUNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
    logic [REG_ADDR_WIDTH-1:0] id_rs, id_rt, ex_rt;
    logic                    load_use;
    logic                    redirect;
    logic                    stall_ev;

    assign id_rs = hz.id_rs_i;
    assign id_rt = hz.id_rt_i;
    assign ex_rt = hz.ex_rt_i;

    always_comb begin
        load_use = hz.ex_mem_read_i && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (hz.id_uses_rt_i && (ex_rt == id_rt)));
        redirect = hz.mem_branch_taken_i || hz.ex_jump_i;
        // STALL ignores load_use so the bubble is capped at one cycle
        stall_ev = load_use && !redirect && (state_q != STALL);
    end

    // Outputs fall back to plain advance while reset is held low
    always_comb begin
        hz.pc_enable_o   = 1'b1;
        hz.ifid_enable_o = 1'b1;
        hz.ifid_flush_o  = 1'b0;
        hz.idex_flush_o  = 1'b0;
        hz.exmem_flush_o = 1'b0;
        if (reset) begin
            if (hz.mem_branch_taken_i) begin
                hz.ifid_flush_o  = 1'b1;
                hz.idex_flush_o  = 1'b1;
                hz.exmem_flush_o = 1'b1;
            end else if (hz.ex_jump_i) begin
                hz.ifid_flush_o  = 1'b1;
                hz.idex_flush_o  = 1'b1;
            end else if (stall_ev) begin
                hz.pc_enable_o   = 1'b0;
                hz.ifid_enable_o = 1'b0;
                hz.idex_flush_o  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = RUN;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            state_d = REDIRECT;
        end else if (stall_ev) begin
            state_d = STALL;
        end
        if (hz.count_clear_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + COUNT_WIDTH'(1);
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.state_o       = state_q;
    assign hz.stall_count_o = stall_cnt_q;
    assign hz.flush_count_o = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench: each vector pushes its hand-computed response into a
// scoreboard queue; a monitor pops and compares on the falling clock edge.
module tb_pipeline_hazard_controller;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    // {pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush}
    localparam logic [4:0] ADV = 5'b11000;
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] BRF = 5'b11111;
    localparam logic [4:0] JMF = 5'b11110;

    typedef struct {
        string      name;
        logic [4:0] ctl;
        logic [1:0] st;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    pipeline_hazard_controller_if #(.REG_ADDR_WIDTH(RW), .COUNT_WIDTH(CW)) hz ();

    pipeline_hazard_controller #(.REG_ADDR_WIDTH(RW), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %b want %b", nm, got, want);
    endtask

    // Monitor: the controller presents a response every cycle
    initial begin
        exp_t e;
        logic [4:0] ctl;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                ctl = {hz.pc_enable_o, hz.ifid_enable_o, hz.ifid_flush_o,
                       hz.idex_flush_o, hz.exmem_flush_o};
                check({e.name, ".ctl"},   {3'b0, ctl},            {3'b0, e.ctl});
                check({e.name, ".state"}, {6'b0, hz.state_o},     {6'b0, e.st});
                check({e.name, ".stall"}, {4'b0, hz.stall_count_o}, {4'b0, e.sc});
                check({e.name, ".flush"}, {4'b0, hz.flush_count_o}, {4'b0, e.fc});
            end
        end
    end

    task automatic step(input string nm, input logic rst, input logic mr,
                        input logic [4:0] exrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic uses, input logic jmp,
                        input logic br, input logic clr, input logic [4:0] ctl,
                        input logic [1:0] st, input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset                 = rst;
        hz.ex_mem_read_i      = mr;
        hz.ex_rt_i            = exrt;
        hz.id_rs_i            = rs;
        hz.id_rt_i            = rt;
        hz.id_uses_rt_i       = uses;
        hz.ex_jump_i          = jmp;
        hz.mem_branch_taken_i = br;
        hz.count_clear_i      = clr;
        e.name = nm; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
        sb.push_back(e);
    endtask

    initial begin
        int s;
        hz.ex_mem_read_i = 1'b0; hz.ex_rt_i = '0; hz.id_rs_i = '0; hz.id_rt_i = '0;
        hz.id_uses_rt_i = 1'b0; hz.ex_jump_i = 1'b0; hz.mem_branch_taken_i = 1'b0;
        hz.count_clear_i = 1'b0;

        //    name          rst mr exrt rs rt us jmp br clr  ctl  st  sc  fc
        step("rst_hold",     0, 1, 8, 8, 0, 0, 0, 0, 0, ADV, 0, 0, 0);
        step("idle0",        1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0, 0);
        step("lu_rs",        1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 0, 0, 0);
        step("in_stall",     1, 1, 8, 8, 0, 0, 0, 0, 0, ADV, 1, 1, 0);
        step("resume",       1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 1, 0);
        step("addi_rt",      1, 1, 8, 3, 8, 0, 0, 0, 0, ADV, 0, 1, 0);
        step("reg0",         1, 1, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 1, 0);
        step("lu_rt",        1, 1, 9, 2, 9, 1, 0, 0, 0, STL, 0, 1, 0);
        step("clr_stall",    1, 0, 0, 0, 0, 0, 0, 0, 1, ADV, 1, 2, 0);
        step("br_lu",        1, 1, 8, 8, 0, 0, 0, 1, 0, BRF, 0, 0, 0);
        step("after_br",     1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 2, 0, 1);
        step("jump",         1, 0, 0, 0, 0, 0, 1, 0, 0, JMF, 0, 0, 1);
        step("jump_lu",      1, 1, 8, 8, 0, 0, 1, 0, 0, JMF, 2, 0, 2);
        step("lu_redir",     1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 2, 0, 3);
        step("stall2",       1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1, 1, 3);
        step("br_jump",      1, 0, 0, 0, 0, 0, 1, 1, 0, BRF, 0, 1, 3);
        step("after_bj",     1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 2, 1, 4);

        for (int i = 0; i < 20; i++) begin
            s = (i + 1 > 15) ? 15 : i + 1;
            step($sformatf("sat_lu%0d", i), 1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 0, 4'(s), 4);
            s = (i + 2 > 15) ? 15 : i + 2;
            step($sformatf("sat_id%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1, 4'(s), 4);
        end

        step("sat_hold",     1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 0, 15, 4);
        step("sat_hold_id",  1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1, 15, 4);
        step("clr_lu",       1, 1, 8, 8, 0, 0, 0, 0, 1, STL, 0, 15, 4);
        step("cleared",      1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1, 0, 0);
        step("pre_lu1",      1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 0, 0, 0);
        step("pre_id1",      1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1, 1, 0);
        step("pre_lu2",      1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 0, 1, 0);
        step("pre_id2",      1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1, 2, 0);
        step("pre_lu3",      1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 0, 2, 0);
        step("async_rst",    0, 1, 8, 8, 0, 0, 0, 0, 0, ADV, 0, 0, 0);
        step("post_rst_lu",  1, 1, 8, 8, 0, 0, 0, 0, 0, STL, 0, 0, 0);
        step("post_rst_st",  1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1, 1, 0);

        for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
